control_decoder: RTL and testbench

Sequential decoder for 8-bit one-hot-range control words, the inverse of the Mm-to-control generation path in code_comb. It accepts a control word over a valid/ready handshake and scans it one bit per clock. It recovers the two 3-bit digit positions (highest set bit M, lowest set bit m) as a packed 6-bit Mm, together with a population count and an error flag. It sits between the control bus and any consumer that needs the digit pair back, such as self-check logic or display.

---
 rtl/control_decoder_if.sv | 22 ++
 rtl/control_decoder.sv | 116 +++++++++++
 tb/tb_control_decoder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/control_decoder_if.sv
// Handshake bundle between the control bus and the control_decoder.
// The master drives control words in and takes results; the slave is the decoder.
interface control_decoder_if;
   logic [7:0] control;
   logic       in_valid;
   logic       in_ready;
   logic [5:0] Mm;
   logic [3:0] ones;
   logic       err;
   logic       out_valid;
   logic       out_ready;

   modport master (
      output control, in_valid, out_ready,
      input  in_ready, Mm, ones, err, out_valid
   );

   modport slave (
      input  control, in_valid, out_ready,
      output in_ready, Mm, ones, err, out_valid
   );
endinterface

// File: rtl/control_decoder.sv
// Bit-serial decoder: recovers highest/lowest set-bit positions (Mm), popcount
// and a contiguity error flag from an 8-bit one-hot-range control word.
module control_decoder (
   input logic         clk,
   input logic         reset,
   control_decoder_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t     state_q;
   logic [7:0] word_q;
   logic [2:0] idx_q;
   logic [2:0] hi_q, hi_d;
   logic [2:0] lo_q, lo_d;
   logic [3:0] cnt_q, cnt_d;
   logic       seen_one_q, seen_one_d;
   logic       seen_gap_q, seen_gap_d;
   logic       noncontig_q, noncontig_d;
   logic [5:0] mm_q;
   logic [3:0] ones_q;
   logic       err_q;
   logic       out_valid_q;
   logic       bit_cur;

   // Effect of the bit under examination, so the last bit lands in the result.
   always_comb begin
      bit_cur     = word_q[idx_q];
      hi_d        = hi_q;
      lo_d        = lo_q;
      cnt_d       = cnt_q;
      seen_one_d  = seen_one_q;
      seen_gap_d  = seen_gap_q;
      noncontig_d = noncontig_q;
      if (bit_cur) begin
         if (!seen_one_q) begin
            lo_d = idx_q;
         end
         seen_one_d = 1'b1;
         hi_d       = idx_q;
         cnt_d      = cnt_q + 4'd1;
         if (seen_gap_q) begin
            noncontig_d = 1'b1;
         end
      end else if (seen_one_q) begin
         seen_gap_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         word_q      <= '0;
         idx_q       <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         cnt_q       <= '0;
         seen_one_q  <= 1'b0;
         seen_gap_q  <= 1'b0;
         noncontig_q <= 1'b0;
         mm_q        <= '0;
         ones_q      <= '0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  word_q      <= bus.control;
                  idx_q       <= '0;
                  hi_q        <= '0;
                  lo_q        <= '0;
                  cnt_q       <= '0;
                  seen_one_q  <= 1'b0;
                  seen_gap_q  <= 1'b0;
                  noncontig_q <= 1'b0;
                  state_q     <= SCAN;
               end
            end
            SCAN: begin
               hi_q        <= hi_d;
               lo_q        <= lo_d;
               cnt_q       <= cnt_d;
               seen_one_q  <= seen_one_d;
               seen_gap_q  <= seen_gap_d;
               noncontig_q <= noncontig_d;
               if (idx_q == 3'd7) begin
                  mm_q        <= {hi_d, lo_d};
                  ones_q      <= cnt_d;
                  err_q       <= !seen_one_d || noncontig_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  idx_q <= idx_q + 3'd1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = (state_q == IDLE) && !reset;
   assign bus.out_valid = out_valid_q;
   assign bus.Mm        = mm_q;
   assign bus.ones      = ones_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_control_decoder.sv
// Directed-vector bench for control_decoder with hand-computed expectations.
module tb_control_decoder;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;

   control_decoder_if bus ();

   control_decoder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input string tag, input logic [7:0] w);
      int t = 0;
      while (!bus.in_ready && t < 30) begin
         tick();
         t++;
      end
      check({tag, "_ready_before"}, 32'(bus.in_ready), 32'd1);
      bus.control  = w;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      check({tag, "_busy_after"}, 32'(bus.in_ready), 32'd0);
   endtask

   task automatic wait_result(input string tag);
      int lat = 0;
      while (!bus.out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'd8);
   endtask

   task automatic run_word(input string tag, input logic [7:0] w,
                           input logic [5:0] e_mm, input logic [3:0] e_ones, input logic e_err);
      bus.out_ready = 1'b1;
      accept(tag, w);
      wait_result(tag);
      check({tag, "_mm"},   32'(bus.Mm),       32'(e_mm));
      check({tag, "_ones"}, 32'(bus.ones),     32'(e_ones));
      check({tag, "_err"},  32'(bus.err),      32'(e_err));
      check({tag, "_rdy0"}, 32'(bus.in_ready), 32'd0);
      tick();
      check({tag, "_vld_drop"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_rdy_back"}, 32'(bus.in_ready),  32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int highs;
      reset         = 1'b1;
      bus.control   = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      check("rst_in_ready",  32'(bus.in_ready),  32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_mm",        32'(bus.Mm),        32'd0);
      check("rst_ones",      32'(bus.ones),      32'd0);
      check("rst_err",       32'(bus.err),       32'd0);
      reset = 1'b0;
      #1;
      check("rst_release_ready", 32'(bus.in_ready), 32'd1);

      run_word("w1c",  8'b00011100, 6'b100010, 4'd3, 1'b0);
      run_word("w01",  8'b00000001, 6'b000000, 4'd1, 1'b0);
      run_word("wff",  8'hFF,       6'b111000, 4'd8, 1'b0);
      run_word("w00",  8'h00,       6'b000000, 4'd0, 1'b1);
      run_word("wa0",  8'b10100000, 6'b111101, 4'd2, 1'b1);

      // Backpressure: result held while out_ready stays low; in_valid ignored.
      bus.out_ready = 1'b0;
      accept("bp", 8'b01100000);
      wait_result("bp");
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_vld",  32'(bus.out_valid), 32'd1);
         check("bp_hold_mm",   32'(bus.Mm),        32'(6'b110101));
         check("bp_hold_ones", 32'(bus.ones),      32'd2);
         check("bp_hold_rdy",  32'(bus.in_ready),  32'd0);
         bus.control  = 8'hFF;
         bus.in_valid = 1'b1;
         tick();
      end
      bus.in_valid = 1'b0;
      check("bp_still_vld", 32'(bus.out_valid), 32'd1);
      check("bp_still_mm",  32'(bus.Mm),        32'(6'b110101));
      bus.out_ready = 1'b1;
      tick();
      check("bp_vld_drop", 32'(bus.out_valid), 32'd0);
      check("bp_rdy_back", 32'(bus.in_ready),  32'd1);
      tick();
      check("bp_no_queue_vld", 32'(bus.out_valid), 32'd0);
      check("bp_no_queue_rdy", 32'(bus.in_ready),  32'd1);

      // Reset while idx_q==4: word discarded, outputs cleared.
      accept("rs", 8'b00111000);
      repeat (4) tick();
      reset = 1'b1;
      #1;
      check("rs_ready_low", 32'(bus.in_ready), 32'd0);
      tick();
      reset = 1'b0;
      #1;
      check("rs_ready_back", 32'(bus.in_ready),  32'd1);
      check("rs_vld",        32'(bus.out_valid), 32'd0);
      check("rs_mm_clr",     32'(bus.Mm),        32'd0);
      check("rs_ones_clr",   32'(bus.ones),      32'd0);
      highs = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.out_valid) highs++;
      end
      check("rs_no_result", 32'(highs), 32'd0);
      run_word("w06", 8'b00000110, 6'b010001, 4'd2, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
